// File: rtl/gpr_wbpipe.sv
// General-purpose register file with a configurable write-back delay pipeline,
// youngest-first read forwarding and a kill that drops uncommitted writes.
module gpr_wbpipe #(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int NRD       = 2,
  parameter int WB_STAGES = 1,
  parameter int BYPASS_IN = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                kill,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [1:0]          pend_cnt,
  output logic                commit_en,
  output logic [AW-1:0]       commit_addr,
  output logic [XLEN-1:0]     commit_data
);

  // Keep at least one stage slot so the arrays stay legal when WB_STAGES is 0.
  localparam int NS = (WB_STAGES > 0) ? WB_STAGES : 1;

  logic            stg_valid_r [NS];
  logic [AW-1:0]   stg_addr_r  [NS];
  logic [XLEN-1:0] stg_data_r  [NS];
  logic [XLEN-1:0] regs_r      [NREGS];

  logic            wr_req_s;
  logic            cmt_en_s;
  logic [AW-1:0]   cmt_addr_s;
  logic [XLEN-1:0] cmt_data_s;
  logic [1:0]      pend_nxt_s;
  logic [AW-1:0]   rd_ra_s     [NRD];
  logic            rd_hit_s    [NRD];
  logic [XLEN-1:0] rd_fwd_s    [NRD];

  assign wr_req_s = wb_en && (wb_addr != {AW{1'b0}});

  // Select the array write source: the input itself or the oldest stage.
  always_comb begin
    cmt_en_s   = 1'b0;
    cmt_addr_s = {AW{1'b0}};
    cmt_data_s = {XLEN{1'b0}};
    if (WB_STAGES == 0) begin
      cmt_en_s   = wr_req_s;
      cmt_addr_s = wb_addr;
      cmt_data_s = wb_data;
    end else begin
      cmt_en_s   = stg_valid_r[NS-1];
      cmt_addr_s = stg_addr_r[NS-1];
      cmt_data_s = stg_data_r[NS-1];
    end
  end

  // Next occupancy: the new write plus every stage that shifts down a slot.
  always_comb begin
    pend_nxt_s = 2'd0;
    if ((WB_STAGES > 0) && !kill) begin
      pend_nxt_s = {1'b0, wr_req_s};
      for (int s = 0; s < NS - 1; s++) begin
        pend_nxt_s = pend_nxt_s + {1'b0, stg_valid_r[s]};
      end
    end else begin
      pend_nxt_s = 2'd0;
    end
  end

  // Write-back delay stages; kill clears every valid including the new load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NS; s++) begin
        stg_valid_r[s] <= 1'b0;
        stg_addr_r[s]  <= {AW{1'b0}};
        stg_data_r[s]  <= {XLEN{1'b0}};
      end
    end else begin
      stg_valid_r[0] <= (WB_STAGES > 0) && wr_req_s && !kill;
      stg_addr_r[0]  <= wb_addr;
      stg_data_r[0]  <= wb_data;
      for (int s = 1; s < NS; s++) begin
        stg_valid_r[s] <= stg_valid_r[s-1] && !kill;
        stg_addr_r[s]  <= stg_addr_r[s-1];
        stg_data_r[s]  <= stg_data_r[s-1];
      end
    end
  end

  // Architectural register array; x0 is never a commit target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (cmt_en_s) begin
      regs_r[cmt_addr_s] <= cmt_data_s;
    end
  end

  // Registered commit report and occupancy count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_en   <= 1'b0;
      commit_addr <= {AW{1'b0}};
      commit_data <= {XLEN{1'b0}};
      pend_cnt    <= 2'd0;
    end else begin
      commit_en   <= cmt_en_s;
      commit_addr <= cmt_en_s ? cmt_addr_s : {AW{1'b0}};
      commit_data <= cmt_en_s ? cmt_data_s : {XLEN{1'b0}};
      pend_cnt    <= pend_nxt_s;
    end
  end

  // Read ports: x0, then input forward, then youngest stage, then array.
  always_comb begin
    rd_data = {(NRD*XLEN){1'b0}};
    for (int p = 0; p < NRD; p++) begin
      rd_ra_s[p]  = rd_addr[p*AW +: AW];
      rd_hit_s[p] = 1'b0;
      rd_fwd_s[p] = {XLEN{1'b0}};
      // Scan oldest to youngest so the youngest match is the one that sticks.
      for (int s = NS - 1; s >= 0; s--) begin
        if (stg_valid_r[s] && (stg_addr_r[s] == rd_ra_s[p])) begin
          rd_hit_s[p] = 1'b1;
          rd_fwd_s[p] = stg_data_r[s];
        end else begin
          rd_hit_s[p] = rd_hit_s[p];
          rd_fwd_s[p] = rd_fwd_s[p];
        end
      end
      if (rd_ra_s[p] == {AW{1'b0}}) begin
        rd_data[p*XLEN +: XLEN] = {XLEN{1'b0}};
      end else if ((BYPASS_IN != 0) && wb_en && (wb_addr == rd_ra_s[p])) begin
        rd_data[p*XLEN +: XLEN] = wb_data;
      end else if (rd_hit_s[p]) begin
        rd_data[p*XLEN +: XLEN] = rd_fwd_s[p];
      end else begin
        rd_data[p*XLEN +: XLEN] = regs_r[rd_ra_s[p]];
      end
    end
  end

endmodule
